// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control and the mul/div unit.
package mips_ctrl_pkg;

  // R-type funct fields
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  // Immediate-form opcodes
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_XORI = 6'b001110;

  // Main-control ALUOp classes
  localparam logic [1:0] CTRL_LDST   = 2'b00;
  localparam logic [1:0] CTRL_BRANCH = 2'b01;
  localparam logic [1:0] CTRL_RTYPE  = 2'b10;
  localparam logic [1:0] CTRL_IMM    = 2'b11;

  // ALU operation codes
  localparam logic [3:0] ALU_AND       = 4'b0000;
  localparam logic [3:0] ALU_OR        = 4'b0001;
  localparam logic [3:0] ALU_ADD       = 4'b0010;
  localparam logic [3:0] ALU_SLL       = 4'b0011;
  localparam logic [3:0] ALU_SRL       = 4'b0100;
  localparam logic [3:0] ALU_SLLV      = 4'b0101;
  localparam logic [3:0] ALU_SUB       = 4'b0110;
  localparam logic [3:0] ALU_SLT       = 4'b0111;
  localparam logic [3:0] ALU_SRLV      = 4'b1000;
  localparam logic [3:0] ALU_NOR       = 4'b1100;
  localparam logic [3:0] ALU_XOR       = 4'b1101;
  localparam logic [3:0] ALUOP_ILLEGAL = 4'b1111;

  // EX result mux select
  localparam logic [1:0] HILO_SEL_ALU = 2'b00;
  localparam logic [1:0] HILO_SEL_HI  = 2'b01;
  localparam logic [1:0] HILO_SEL_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Order matches funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_e;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per step, with sign fix-up applied to the final result.
module muldiv_iter
  import mips_ctrl_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  muldiv_op_e       op,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             done,
  output logic [NBITS-1:0] res_hi,
  output logic [NBITS-1:0] res_lo
);

  logic [CNTBITS-1:0] cnt;
  logic               is_div;
  logic               neg_hi;
  logic               neg_lo;
  logic [NBITS-1:0]   a_raw;
  logic [NBITS-1:0]   opnd;
  logic [NBITS-1:0]   work_hi;
  logic [NBITS-1:0]   work_lo;

  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [NBITS-1:0]   mag_a;
  logic [NBITS-1:0]   mag_b;
  logic [NBITS:0]     mul_sum;
  logic [NBITS:0]     div_shift;
  logic [NBITS-1:0]   div_diff;
  logic               div_ok;
  logic               div_zero;
  logic               last;
  logic [NBITS-1:0]   nxt_hi;
  logic [NBITS-1:0]   nxt_lo;
  logic [2*NBITS-1:0] prod;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);
  assign a_neg     = op_signed & a[NBITS-1];
  assign b_neg     = op_signed & b[NBITS-1];

  // The magnitude of -2^(NBITS-1) is 2^(NBITS-1), which fits as an unsigned
  // NBITS-bit value; the accumulate/compare paths below carry the extra bit.
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // Operand latch on start, then one iteration per step until done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      a_raw   <= '0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else if (start) begin
      cnt     <= '0;
      is_div  <= op_div;
      neg_hi  <= op_div ? a_neg : (a_neg ^ b_neg);
      neg_lo  <= a_neg ^ b_neg;
      a_raw   <= a;
      opnd    <= op_div ? mag_b : mag_a;
      work_hi <= '0;
      work_lo <= op_div ? mag_a : mag_b;
    end else if (step && !div_zero) begin
      work_hi <= nxt_hi;
      work_lo <= nxt_lo;
      cnt     <= cnt + CNTBITS'(1);
    end
  end

  // One iteration: multiply shifts the low word right through the accumulator,
  // divide shifts the dividend left into the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[NBITS-1]};
    div_ok    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[NBITS-1:0] - opnd;
    if (is_div) begin
      nxt_hi = div_ok ? div_diff : div_shift[NBITS-1:0];
      nxt_lo = {work_lo[NBITS-2:0], div_ok};
    end else begin
      nxt_hi = mul_sum[NBITS:1];
      nxt_lo = {mul_sum[0], work_lo[NBITS-1:1]};
    end
  end

  assign div_zero = is_div && (opnd == '0);
  assign last     = cnt == CNTBITS'(NBITS - 1);
  assign done     = step && (div_zero || last);
  assign prod     = neg_hi ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};

  // Final result including sign fix-up; only consumed on the done cycle.
  always_comb begin
    res_hi = prod[2*NBITS-1:NBITS];
    res_lo = prod[NBITS-1:0];
    if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = neg_hi ? -nxt_hi : nxt_hi;
      res_lo = neg_lo ? -nxt_lo : nxt_lo;
    end
  end

endmodule

// File: rtl/control_alu_muldiv.sv
// EX-stage ALU control: opcode/funct decode, multi-cycle MULT/DIV sequencing with
// HI/LO registers, MFxx/MTxx handling and pipeline stall generation.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no mul/div in flight; decode, MFxx and MTxx active
//  MUL     | shift-add multiply iterating, pipeline stalled
//  DIV     | restoring divide iterating (or div-by-zero), pipeline stalled
//  DONE    | result in HI/LO, stall released, held MULT/DIV is ignored
module control_alu_muldiv
  import mips_ctrl_pkg::*;
#(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4,
  parameter int CNTBITS      = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_Valid,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [NBITS-1:0]        i_RegA,
  input  logic [NBITS-1:0]        i_RegB,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic [1:0]              o_HILOSel,
  output logic [NBITS-1:0]        o_HILO,
  output logic                    o_Stall,
  output logic                    o_Busy
);

  state_e           state;
  state_e           state_nxt;
  logic [NBITS-1:0] hi;
  logic [NBITS-1:0] lo;
  logic [3:0]       alu_op;
  logic             rtype;
  logic             start;
  logic             md_start;
  logic             md_step;
  logic             md_done;
  muldiv_op_e       md_op;
  logic [NBITS-1:0] md_hi;
  logic [NBITS-1:0] md_lo;

  assign rtype    = i_ALUOp == CTRL_RTYPE;
  assign start    = i_Valid && rtype && is_muldiv_funct(i_Funct);
  assign md_op    = muldiv_op_e'(i_Funct[1:0]);
  assign md_start = (state == ST_IDLE) && start;
  assign md_step  = (state == ST_MUL) || (state == ST_DIV);

  // ALU operation decode; mul/div and HI/LO moves produce the illegal code.
  always_comb begin
    alu_op = ALUOP_ILLEGAL;
    case (i_ALUOp)
      CTRL_LDST:   alu_op = ALU_ADD;
      CTRL_BRANCH: alu_op = ALU_SUB;
      CTRL_RTYPE: begin
        case (i_Funct)
          FUNCT_ADD:  alu_op = ALU_ADD;
          FUNCT_SUB:  alu_op = ALU_SUB;
          FUNCT_AND:  alu_op = ALU_AND;
          FUNCT_OR:   alu_op = ALU_OR;
          FUNCT_NOR:  alu_op = ALU_NOR;
          FUNCT_XOR:  alu_op = ALU_XOR;
          FUNCT_SLT:  alu_op = ALU_SLT;
          FUNCT_SLL:  alu_op = ALU_SLL;
          FUNCT_SRL:  alu_op = ALU_SRL;
          FUNCT_SLLV: alu_op = ALU_SLLV;
          FUNCT_SRLV: alu_op = ALU_SRLV;
          default:    alu_op = ALUOP_ILLEGAL;
        endcase
      end
      CTRL_IMM: begin
        case (i_Opcode)
          OPC_SLTI: alu_op = ALU_SLT;
          OPC_ANDI: alu_op = ALU_AND;
          OPC_ORI:  alu_op = ALU_OR;
          OPC_XORI: alu_op = ALU_XOR;
          default:  alu_op = ALUOP_ILLEGAL;
        endcase
      end
      default: alu_op = ALUOP_ILLEGAL;
    endcase
  end

  assign o_ALUOp = alu_op;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state, stall/busy and HI/LO read mux.
  always_comb begin
    state_nxt = state;
    o_Stall   = 1'b0;
    o_Busy    = 1'b0;
    o_HILOSel = HILO_SEL_ALU;
    o_HILO    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          o_Stall   = 1'b1;
          state_nxt = ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        o_Stall = 1'b1;
        o_Busy  = 1'b1;
        if (md_done) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (((state == ST_IDLE) || (state == ST_DONE)) && rtype) begin
      if (i_Funct == FUNCT_MFHI) begin
        o_HILOSel = HILO_SEL_HI;
        o_HILO    = hi;
      end else if (i_Funct == FUNCT_MFLO) begin
        o_HILOSel = HILO_SEL_LO;
        o_HILO    = lo;
      end
    end
  end

  // HI/LO: written by the mul/div result, or by MTHI/MTLO while idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi <= '0;
      lo <= '0;
    end else if (md_done) begin
      hi <= md_hi;
      lo <= md_lo;
    end else if ((state == ST_IDLE) && i_Valid && rtype) begin
      if (i_Funct == FUNCT_MTHI) hi <= i_RegA;
      if (i_Funct == FUNCT_MTLO) lo <= i_RegA;
    end
  end

  muldiv_iter #(
    .NBITS   (NBITS),
    .CNTBITS (CNTBITS)
  ) u_muldiv (
    .clk    (i_clk),
    .reset  (i_reset),
    .start  (md_start),
    .step   (md_step),
    .op     (md_op),
    .a      (i_RegA),
    .b      (i_RegB),
    .done   (md_done),
    .res_hi (md_hi),
    .res_lo (md_lo)
  );

endmodule

// File: tb/tb_control_alu_muldiv.sv
module tb_control_alu_muldiv;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_Valid;
  logic [5:0]  i_Funct;
  logic [5:0]  i_Opcode;
  logic [1:0]  i_ALUOp;
  logic [31:0] i_RegA;
  logic [31:0] i_RegB;
  logic [3:0]  o_ALUOp;
  logic [1:0]  o_HILOSel;
  logic [31:0] o_HILO;
  logic        o_Stall;
  logic        o_Busy;

  int n_checks = 0;
  int n_errors = 0;

  control_alu_muldiv dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_Valid   (i_Valid),
    .i_Funct   (i_Funct),
    .i_Opcode  (i_Opcode),
    .i_ALUOp   (i_ALUOp),
    .i_RegA    (i_RegA),
    .i_RegB    (i_RegB),
    .o_ALUOp   (o_ALUOp),
    .o_HILOSel (o_HILOSel),
    .o_HILO    (o_HILO),
    .o_Stall   (o_Stall),
    .o_Busy    (o_Busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic dec_check(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [5:0] opc, input logic [3:0] exp);
    i_Valid  = 1'b0;
    i_ALUOp  = aluop;
    i_Funct  = funct;
    i_Opcode = opc;
    #1;
    chk(tag, 64'(o_ALUOp), 64'(exp));
  endtask

  // Issue a mul/div, hold it while stalled, then read HI and LO back with MFHI/MFLO.
  task automatic run_md(input string tag, input logic [5:0] funct, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    i_Valid = 1'b1;
    i_ALUOp = 2'b10;
    i_Funct = funct;
    i_RegA  = a;
    i_RegB  = b;
    #1;
    cnt = 0;
    while (o_Stall && cnt < 200) begin
      cnt++;
      if (cnt == 1) chk({tag, "_busy_start"}, 64'(o_Busy), 64'd0);
      if (cnt == 2) chk({tag, "_busy_run"}, 64'(o_Busy), 64'd1);
      tick();
    end
    chk({tag, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
    chk({tag, "_busy_done"}, 64'(o_Busy), 64'd0);
    tick();
    i_Funct = F_MFHI;
    #1;
    chk({tag, "_no_restart"}, 64'(o_Stall), 64'd0);
    chk({tag, "_sel_hi"}, 64'(o_HILOSel), 64'd1);
    chk({tag, "_hi"}, 64'(o_HILO), 64'(exp_hi));
    i_Funct = F_MFLO;
    #1;
    chk({tag, "_sel_lo"}, 64'(o_HILOSel), 64'd2);
    chk({tag, "_lo"}, 64'(o_HILO), 64'(exp_lo));
    i_Valid = 1'b0;
    i_Funct = 6'b000000;
    tick();
  endtask

  initial begin
    i_reset  = 1'b1;
    i_Valid  = 1'b0;
    i_Funct  = 6'b000000;
    i_Opcode = 6'b000000;
    i_ALUOp  = 2'b00;
    i_RegA   = 32'd0;
    i_RegB   = 32'd0;
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("rst_stall", 64'(o_Stall), 64'd0);
    chk("rst_busy", 64'(o_Busy), 64'd0);
    chk("rst_sel", 64'(o_HILOSel), 64'd0);
    i_ALUOp = 2'b10;
    i_Funct = F_MFHI;
    #1;
    chk("rst_hi", 64'(o_HILO), 64'd0);
    i_Funct = F_MFLO;
    #1;
    chk("rst_lo", 64'(o_HILO), 64'd0);

    // Decode
    dec_check("dec_and",   2'b10, F_AND,     6'd0,      4'b0000);
    chk("dec_and_stall", 64'(o_Stall), 64'd0);
    dec_check("dec_bad",   2'b10, 6'b111111, 6'd0,      4'b1111);
    dec_check("dec_add",   2'b10, 6'b100000, 6'd0,      4'b0010);
    dec_check("dec_sub",   2'b10, 6'b100010, 6'd0,      4'b0110);
    dec_check("dec_nor",   2'b10, 6'b100111, 6'd0,      4'b1100);
    dec_check("dec_slt",   2'b10, 6'b101010, 6'd0,      4'b0111);
    dec_check("dec_srlv",  2'b10, 6'b000110, 6'd0,      4'b1000);
    dec_check("dec_sll",   2'b10, 6'b000000, 6'd0,      4'b0011);
    dec_check("dec_mult",  2'b10, F_MULT,    6'd0,      4'b1111);
    dec_check("dec_ldst",  2'b00, 6'b100100, 6'd0,      4'b0010);
    dec_check("dec_br",    2'b01, 6'b100100, 6'd0,      4'b0110);
    dec_check("dec_xori",  2'b11, 6'd0,      6'b001110, 4'b1101);
    dec_check("dec_slti",  2'b11, 6'd0,      6'b001010, 4'b0111);
    dec_check("dec_addi",  2'b11, 6'd0,      6'b001000, 4'b1111);
    chk("dec_invalid_no_stall", 64'(o_Stall), 64'd0);
    tick();

    // Multiply / divide
    run_md("mult_m3x7",   F_MULT,  32'hFFFF_FFFD, 32'd7,        33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("divu_100_7",  F_DIVU,  32'd100,       32'd7,        33, 32'd2,         32'd14);
    run_md("div_m7_2",    F_DIV,   32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_5_0",     F_DIV,   32'd5,         32'd0,         2, 32'd5,         32'hFFFF_FFFF);
    run_md("div_min_m1",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,        32'h8000_0000);
    run_md("multu_max",   F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult_minsq",  F_MULT,  32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000);
    run_md("div_7_m2",    F_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD);

    // Reset on the 10th cycle of a MULT
    i_Valid = 1'b1;
    i_ALUOp = 2'b10;
    i_Funct = F_MULT;
    i_RegA  = 32'hFFFF_FFFD;
    i_RegB  = 32'd7;
    #1;
    repeat (9) tick();
    chk("abort_busy_before", 64'(o_Busy), 64'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_Valid = 1'b0;
    #1;
    chk("abort_stall", 64'(o_Stall), 64'd0);
    chk("abort_busy", 64'(o_Busy), 64'd0);
    i_Funct = F_MFHI;
    #1;
    chk("abort_hi", 64'(o_HILO), 64'd0);
    i_Funct = F_MFLO;
    #1;
    chk("abort_lo", 64'(o_HILO), 64'd0);
    tick();
    run_md("mult_6x7", F_MULT, 32'd6, 32'd7, 33, 32'd0, 32'd42);

    // MTHI / MTLO
    i_Valid = 1'b1;
    i_ALUOp = 2'b10;
    i_Funct = F_MTHI;
    i_RegA  = 32'h1234_5678;
    tick();
    i_Funct = F_MFHI;
    #1;
    chk("mthi_sel", 64'(o_HILOSel), 64'd1);
    chk("mthi_val", 64'(o_HILO), 64'h1234_5678);
    i_Valid = 1'b0;
    i_Funct = F_MTHI;
    i_RegA  = 32'hDEAD_BEEF;
    tick();
    i_Funct = F_MFHI;
    #1;
    chk("mthi_invalid", 64'(o_HILO), 64'h1234_5678);
    i_Valid = 1'b1;
    i_Funct = F_MTLO;
    i_RegA  = 32'hA5A5_0F0F;
    tick();
    i_Funct = F_MFLO;
    #1;
    chk("mtlo_val", 64'(o_HILO), 64'hA5A5_0F0F);
    i_Funct = F_MFHI;
    #1;
    chk("mtlo_hi_kept", 64'(o_HILO), 64'h1234_5678);
    i_Valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
